encoder16to4_seq: RTL and testbench

ENCODER16TO4_SEQ -- requirements
Module: encoder16to4_seq

---
 rtl/encoder16to4_seq.sv | 129 ++++++++++++
 tb/tb_encoder16to4_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/encoder16to4_seq.sv
// Sequential 16-to-4 priority encoder: captures active-low requests and drains them lowest index first.
// Optional macro ENC_LAST_EN adds a 'last' output flagging the final pending code.
module encoder16to4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_n,
  input  logic [15:0] W_n,
  input  logic        ready,
  output logic [3:0]  S,
  output logic        valid,
  output logic        busy,
`ifdef ENC_LAST_EN
  output logic        last,
`endif
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] cleared_s;
  logic [15:0] req_s;
  logic [3:0]  s_q, s_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  assign req_s     = ~W_n;
  assign cleared_s = pending_q & ~(16'h0001 << s_q);

  // Next-state: capture in IDLE, retire one code per accepted transfer in BUSY.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    s_d       = s_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en_n && (W_n != 16'hFFFF)) begin
          state_d   = BUSY;
          pending_d = req_s;
          s_d       = lowest_idx(req_s);
          valid_d   = 1'b1;
        end else begin
          s_d     = 4'h0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (ready) begin
          pending_d = cleared_s;
          if (cleared_s == 16'h0000) begin
            state_d = IDLE;
            s_d     = 4'h0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            s_d     = lowest_idx(cleared_s);
            valid_d = 1'b1;
          end
        end else begin
          pending_d = pending_q;
          s_d       = s_q;
          valid_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 16'h0000;
        s_d       = 4'h0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any partially drained batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 16'h0000;
      s_q       <= 4'h0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      s_q       <= s_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign S     = s_q;
  assign valid = valid_q;
  assign busy  = valid_q;
  assign done  = done_q;

`ifdef ENC_LAST_EN
  logic last_q, last_d;

  assign last_d = valid_d && is_onehot(pending_d);

  // Flags the final code of a batch alongside S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign last = last_q;
`endif

endmodule

// File: tb/tb_encoder16to4_seq.sv
// Self-checking bench for encoder16to4_seq: directed scenarios plus random traffic against a queue model.
module tb_encoder16to4_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_n = 1'b1;
  logic [15:0] W_n = 16'hFFFF;
  logic        ready = 1'b0;
  logic [3:0]  S;
  logic        valid, busy, done;
`ifdef ENC_LAST_EN
  logic        last;
`endif

  int checks = 0;
  int errors = 0;

  int q[$];
  logic exp_done = 1'b0;

  encoder16to4_seq dut (
    .clk(clk), .rst(rst), .en_n(en_n), .W_n(W_n), .ready(ready),
    .S(S), .valid(valid), .busy(busy),
`ifdef ENC_LAST_EN
    .last(last),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       ev;
    logic [3:0] es;
    ev = (q.size() > 0);
    es = ev ? 4'(q[0]) : 4'h0;
    chk({tag, ".valid"}, 16'(valid), 16'(ev));
    chk({tag, ".S"},     16'(S),     16'(es));
    chk({tag, ".busy"},  16'(busy),  16'(ev));
    chk({tag, ".done"},  16'(done),  16'(exp_done));
`ifdef ENC_LAST_EN
    chk({tag, ".last"},  16'(last),  16'(q.size() == 1));
`endif
  endtask

  // Model one clock: drain a code on acceptance, otherwise capture a new batch when idle.
  task automatic cycle(input string tag, input logic e, input logic [15:0] w, input logic r);
    en_n  = e;
    W_n   = w;
    ready = r;
    exp_done = 1'b0;
    if (q.size() > 0) begin
      if (r) begin
        void'(q.pop_front());
        if (q.size() == 0) exp_done = 1'b1;
      end
    end else if (!e && (w != 16'hFFFF)) begin
      for (int i = 0; i < 16; i++) if (!w[i]) q.push_back(i);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check_outputs("reset_async");
    @(posedge clk); #1;
    check_outputs("reset_held");
    rst = 1'b0;

    // single request: code 5
    cycle("single_cap", 1'b0, 16'hFFDF, 1'b1);
    chk("single_S5", 16'(S), 16'd5);
    cycle("single_done", 1'b0, 16'hFFFF, 1'b1);
    chk("single_donepulse", 16'(done), 16'd1);
    cycle("single_idle", 1'b1, 16'hFFFF, 1'b1);

    // two requests with stall
    cycle("stall_cap", 1'b0, 16'h7FFE, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall_hold", 1'b0, 16'h0000, 1'b0);
    cycle("stall_go0", 1'b1, 16'hFFFF, 1'b1);
    chk("stall_S15", 16'(S), 16'd15);
    cycle("stall_go1", 1'b1, 16'hFFFF, 1'b1);
    cycle("stall_idle", 1'b1, 16'hFFFF, 1'b0);

    // full batch, 16 consecutive codes, W_n wiggled while busy
    cycle("full_cap", 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("full_seq", 16'(S), 16'(i));
      cycle("full_drain", 1'b0, 16'(16'hA5A5 ^ i), 1'b1);
    end

    // disabled enable ignores requests
    cycle("ign_en", 1'b1, 16'h0000, 1'b1);
    cycle("ign_en2", 1'b1, 16'h0000, 1'b1);

    // reset mid-batch
    cycle("rst_cap", 1'b0, 16'h0F0F, 1'b1);
    cycle("rst_pre", 1'b0, 16'hFFFF, 1'b1);
    rst = 1'b1;
    q.delete();
    exp_done = 1'b0;
    #1;
    check_outputs("rst_mid_async");
    @(posedge clk); #1;
    check_outputs("rst_mid_held");
    rst = 1'b0;
    cycle("rst_recap", 1'b0, 16'hFF7F, 1'b1);
    cycle("rst_recap_done", 1'b1, 16'hFFFF, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] w;
      case ($urandom_range(0, 3))
        0: w = 16'($urandom);
        1: w = ~(16'h0001 << $urandom_range(0, 15));
        2: w = 16'($urandom) | 16'($urandom) | 16'($urandom);
        default: w = 16'hFFFF;
      endcase
      cycle("rand", 1'($urandom_range(0, 3) == 0), w, 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
